sc_match_scorer: RTL and testbench
==================================

// Module: sc_match_scorer
// PURPOSE
//  Consumes per-lane match pulses and matched note times from the note-matching stage.
//  Grades each hit by timing error against song_time and accumulates score, combo and max combo.
//  Serialises up to 37 simultaneous lane hits through a scan/pipeline.
//  Feeds the HUD/score display; sits directly downstream of note matching.
// PARAMETERS
//  NLANES      37    lane count; must match the note-matching stage
//  PERFECT_WIN 16'd3 |error| <= this -> PERFECT (song_time ticks)
//  GOOD_WIN    16'd8 |error| <= this -> GOOD; larger error -> MISS
//  PERFECT_PTS 8'd10 base points per PERFECT
//  GOOD_PTS    8'd5  base points per GOOD
//  SCORE_W     24    score accumulator width
// PORTS
//  clk          in   1          system clock
//  reset        in   1          synchronous, active-high
//  song_time    in   16         current song time (ticks, wraps mod 2^16)
//  match_trigger in  NLANES     1-cycle pulse per lane: note matched
//  match_time   in   NLANES*16  lane i note time in bits [16*i+15:16*i]; valid with trigger
//  score        out  SCORE_W    running score
//  combo        out  16         current consecutive non-MISS count
//  max_combo    out  16         largest combo reached since reset
//  hit_valid    out  1          1-cycle pulse: one hit graded
//  hit_lane     out  6          lane of graded hit (0..NLANES-1)
//  hit_grade    out  2          0=MISS 1=GOOD 2=PERFECT; valid with hit_valid
//  drop_count   out  8          saturating count of overwritten pending hits
// BEHAVIOUR
//  Reset: every output 0; all pending bits clear; scan pointer 0; pipeline valids clear.
//  Capture, every cycle, all lanes:
//   - match_trigger[i]=1: latch match_time lane i into t_lat[i]; set pend[i].
//   - If pend[i] was already set and not consumed this cycle: overwrite t_lat[i]; drop_count+1, saturating at 255.
//  Scan: ptr steps 0..NLANES-1 every cycle, wraps to 0.
//   - pend[ptr]=1: issue lane ptr into S1; clear pend[ptr].
//   - Trigger on same lane in same cycle: pend stays set, new time latched, no drop counted.
//  S1 (reg): err = song_time - t_lat[ptr], mod 2^16; abs_err = err[15] ? -err : err.
//  S2 (reg): grade from abs_err using inclusive windows; PERFECT checked first.
//  S3 (reg): update score/combo; assert hit_valid/hit_lane/hit_grade for exactly 1 cycle.
//  Latency: a trigger at cycle T is graded into hit_valid at T+1+wait+3.
//   - wait = cycles until ptr reaches the lane, 0..NLANES-1.
//   - Worst case T+40.
//  Throughput: at most one graded hit per cycle.
//  Score/combo update:
//   - MISS: combo <= 0; score unchanged.
//   - GOOD/PERFECT: combo <= combo+1, saturating at 16'hFFFF.
//   - max_combo <= max(max_combo, new combo).
//   - score <= score + base*mult; saturates at 2^SCORE_W-1, never wraps.
//  Reset mid-operation: pending hits and in-flight pipeline stages are discarded; no hit_valid pulse follows.
// CONFIGURATION
//  SC_COMBO_MULT_EN defined:
//   - mult = 1 + min(combo_before_hit/10, 3), i.e. 1..4.
//   - Multiplier computed in S2 from combo as it will stand after preceding in-flight hits.
//  Not defined: mult = 1 always; no multiplier logic synthesised.
// STRUCTURE
//  Shared header sc_score_defs.vh:
//   - localparams GRADE_MISS=2'd0, GRADE_GOOD=2'd1, GRADE_PERFECT=2'd2.
//   - SC_NLANES=37.
//   - Default window and point constants.
//  Sub-module sc_score_grader: S1+S2, abs timing error to grade (+mult).
//  Top holds capture regs, scan pointer, S3 accumulators.
// TESTING
//  1. Lane 5 trigger, match_time=100, song_time=101 -> hit_valid, lane 5, PERFECT; score 10, combo 1.
//  2. Lanes 0, 12, 36 triggered same cycle -> three hit_valid pulses, in scan order from current ptr; no drops.
//  3. Error of 8 -> GOOD (+5); error of 9 -> MISS, combo 0, max_combo retained.
//  4. Wrap: match_time=16'hFFFE, song_time=16'h0001 -> abs_err 3 -> PERFECT.
//  5. Lane 7 triggered twice before scanned -> one hit graded with second time; drop_count=1.
//  6. 40 PERFECTs with SC_COMBO_MULT_EN -> score 10*(10*1+10*2+10*3+10*4)=1000; without it -> 400.
//  7. Reset asserted with 3 hits pending -> no hit_valid afterwards; all outputs 0.

Source files
------------

// File: rtl/sc_match_scorer_pkg.sv
// rtl/sc_match_scorer_pkg.sv - shared grade codes, lane count, window and point defaults
package sc_match_scorer_pkg;

    localparam int          SC_NLANES      = 37;
    localparam int          SC_SCORE_W     = 24;

    localparam logic [1:0]  GRADE_MISS     = 2'd0;
    localparam logic [1:0]  GRADE_GOOD     = 2'd1;
    localparam logic [1:0]  GRADE_PERFECT  = 2'd2;

    localparam logic [15:0] SC_PERFECT_WIN = 16'd3;
    localparam logic [15:0] SC_GOOD_WIN    = 16'd8;
    localparam logic [7:0]  SC_PERFECT_PTS = 8'd10;
    localparam logic [7:0]  SC_GOOD_PTS    = 8'd5;

    // Combo never wraps; it pins at all-ones.
    function automatic logic [15:0] combo_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/sc_score_grader.sv
// rtl/sc_score_grader.sv - S1 abs timing error and S2 grade/multiplier; SC_COMBO_MULT_EN enables combo multiplier
module sc_score_grader
    import sc_match_scorer_pkg::*;
#(
    parameter logic [15:0] PERFECT_WIN = SC_PERFECT_WIN,
    parameter logic [15:0] GOOD_WIN    = SC_GOOD_WIN
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [5:0]  issue_lane,
    input  logic [15:0] song_time,
    input  logic [15:0] note_time,
`ifdef SC_COMBO_MULT_EN
    input  logic [15:0] combo_ahead,
`endif
    output logic        s2_valid,
    output logic [5:0]  s2_lane,
    output logic [1:0]  s2_grade,
    output logic [2:0]  s2_mult
);

    logic        s1_valid;
    logic [5:0]  s1_lane;
    logic [15:0] s1_abs;
    logic [15:0] err_c;
    logic [15:0] abs_c;
    logic [1:0]  grade_c;
    logic [2:0]  mult_c;

    // Timing error is taken modulo 2^16 so song_time wrap is transparent.
    always_comb begin
        err_c = song_time - note_time;
        abs_c = err_c[15] ? (16'd0 - err_c) : err_c;
    end

    // Inclusive windows, tightest window wins.
    always_comb begin
        grade_c = GRADE_MISS;
        if (s1_abs <= PERFECT_WIN)
            grade_c = GRADE_PERFECT;
        else if (s1_abs <= GOOD_WIN)
            grade_c = GRADE_GOOD;
    end

`ifdef SC_COMBO_MULT_EN
    // combo_ahead already includes the hit leaving S2 this cycle, so this is the combo before this hit.
    always_comb begin
        if (combo_ahead >= 16'd30)
            mult_c = 3'd4;
        else if (combo_ahead >= 16'd20)
            mult_c = 3'd3;
        else if (combo_ahead >= 16'd10)
            mult_c = 3'd2;
        else
            mult_c = 3'd1;
    end
`else
    assign mult_c = 3'd1;
`endif

    // S1 and S2 pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_lane  <= '0;
            s1_abs   <= '0;
            s2_valid <= 1'b0;
            s2_lane  <= '0;
            s2_grade <= GRADE_MISS;
            s2_mult  <= 3'd1;
        end else begin
            s1_valid <= issue_valid;
            s1_lane  <= issue_lane;
            s1_abs   <= abs_c;
            s2_valid <= s1_valid;
            s2_lane  <= s1_lane;
            s2_grade <= grade_c;
            s2_mult  <= mult_c;
        end
    end

endmodule

// File: rtl/sc_match_scorer.sv
// rtl/sc_match_scorer.sv - per-lane hit capture, round-robin scan and score/combo accumulation; SC_COMBO_MULT_EN enables combo multiplier
module sc_match_scorer
    import sc_match_scorer_pkg::*;
#(
    parameter int          NLANES      = SC_NLANES,
    parameter logic [15:0] PERFECT_WIN = SC_PERFECT_WIN,
    parameter logic [15:0] GOOD_WIN    = SC_GOOD_WIN,
    parameter logic [7:0]  PERFECT_PTS = SC_PERFECT_PTS,
    parameter logic [7:0]  GOOD_PTS    = SC_GOOD_PTS,
    parameter int          SCORE_W     = SC_SCORE_W
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          song_time,
    input  logic [NLANES-1:0]    match_trigger,
    input  logic [NLANES*16-1:0] match_time,
    output logic [SCORE_W-1:0]   score,
    output logic [15:0]          combo,
    output logic [15:0]          max_combo,
    output logic                 hit_valid,
    output logic [5:0]           hit_lane,
    output logic [1:0]           hit_grade,
    output logic [7:0]           drop_count
);

    logic [15:0]        t_lat [NLANES];
    logic [NLANES-1:0]  pend;
    logic [5:0]         ptr;
    logic               issue;
    logic [15:0]        t_sel;
    logic [5:0]         drops_c;
    logic [8:0]         drop_sum_c;
    logic [7:0]         drop_next_c;

    logic               s2_valid;
    logic [5:0]         s2_lane;
    logic [1:0]         s2_grade;
    logic [2:0]         s2_mult;

    logic [15:0]        combo_next_c;
    logic [15:0]        max_next_c;
    logic [7:0]         pts_c;
    logic [10:0]        add_c;
    logic [SCORE_W:0]   score_sum_c;
    logic [SCORE_W-1:0] score_next_c;

    assign issue = pend[ptr];
    assign t_sel = t_lat[ptr];

    // Count lanes whose still-pending hit is overwritten; the lane being issued is not a drop.
    always_comb begin
        drops_c = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (match_trigger[i] && pend[i] && (ptr != 6'(i)))
                drops_c = drops_c + 6'd1;
        end
        drop_sum_c  = {1'b0, drop_count} + 9'(drops_c);
        drop_next_c = drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
    end

    // Capture: a new trigger always wins over the scan clearing the same lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            drop_count <= '0;
            for (int i = 0; i < NLANES; i++)
                t_lat[i] <= '0;
        end else begin
            drop_count <= drop_next_c;
            for (int i = 0; i < NLANES; i++) begin
                if (match_trigger[i]) begin
                    t_lat[i] <= match_time[16*i +: 16];
                    pend[i]  <= 1'b1;
                end else if (issue && (ptr == 6'(i))) begin
                    pend[i]  <= 1'b0;
                end
            end
        end
    end

    // Scan pointer visits every lane once per NLANES cycles.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (ptr == 6'(NLANES - 1))
            ptr <= '0;
        else
            ptr <= ptr + 6'd1;
    end

    sc_score_grader #(
        .PERFECT_WIN (PERFECT_WIN),
        .GOOD_WIN    (GOOD_WIN)
    ) u_grader (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue),
        .issue_lane  (ptr),
        .song_time   (song_time),
        .note_time   (t_sel),
`ifdef SC_COMBO_MULT_EN
        .combo_ahead (combo_next_c),
`endif
        .s2_valid    (s2_valid),
        .s2_lane     (s2_lane),
        .s2_grade    (s2_grade),
        .s2_mult     (s2_mult)
    );

    // Next accumulator values for the hit leaving S2; also feeds the multiplier lookahead.
    always_comb begin
        combo_next_c = combo;
        pts_c        = 8'd0;
        if (s2_valid) begin
            case (s2_grade)
                GRADE_PERFECT: begin
                    pts_c        = PERFECT_PTS;
                    combo_next_c = combo_inc(combo);
                end
                GRADE_GOOD: begin
                    pts_c        = GOOD_PTS;
                    combo_next_c = combo_inc(combo);
                end
                default: combo_next_c = 16'd0;
            endcase
        end
        max_next_c   = (combo_next_c > max_combo) ? combo_next_c : max_combo;
        add_c        = 11'(pts_c) * 11'(s2_mult);
        score_sum_c  = {1'b0, score} + (SCORE_W + 1)'(add_c);
        score_next_c = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
    end

    // S3: commit accumulators and present the one-cycle hit report.
    always_ff @(posedge clk) begin
        if (reset) begin
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            hit_valid <= 1'b0;
            hit_lane  <= '0;
            hit_grade <= GRADE_MISS;
        end else begin
            score     <= score_next_c;
            combo     <= combo_next_c;
            max_combo <= max_next_c;
            hit_valid <= s2_valid;
            hit_lane  <= s2_lane;
            hit_grade <= s2_grade;
        end
    end

endmodule

// File: tb/tb_sc_match_scorer.sv
// tb/tb_sc_match_scorer.sv - self-checking bench for sc_match_scorer; honours SC_COMBO_MULT_EN
module tb_sc_match_scorer;

    localparam int NL = 37;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      song_time;
    logic [NL-1:0]    match_trigger;
    logic [NL*16-1:0] match_time;
    logic [23:0]      score;
    logic [15:0]      combo;
    logic [15:0]      max_combo;
    logic             hit_valid;
    logic [5:0]       hit_lane;
    logic [1:0]       hit_grade;
    logic [7:0]       drop_count;

    always #5 clk = ~clk;

    sc_match_scorer dut (
        .clk           (clk),
        .reset         (reset),
        .song_time     (song_time),
        .match_trigger (match_trigger),
        .match_time    (match_time),
        .score         (score),
        .combo         (combo),
        .max_combo     (max_combo),
        .hit_valid     (hit_valid),
        .hit_lane      (hit_lane),
        .hit_grade     (hit_grade),
        .drop_count    (drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Reference model: pending lanes, expected hit stream, accumulator totals.
    typedef struct {
        int due;
        int lane;
        int grade;
    } exp_t;

    bit          mpend [NL];
    logic [15:0] mt    [NL];
    int          m_score, m_combo, m_max, m_drop;
    int          cyc;
    exp_t        expq [$];
    bit          armed = 1'b0;
    int          hit_cnt;
    int          hit_lanes [$];
    int          last_lane, last_grade;

    function automatic int grade_of(input logic [15:0] s, input logic [15:0] t);
        logic [15:0] e;
        int a;
        e = s - t;
        a = (e >= 16'h8000) ? 65536 - int'(e) : int'(e);
        if (a <= 3) return 2;
        if (a <= 8) return 1;
        return 0;
    endfunction

    function automatic int mult_of(input int c);
`ifdef SC_COMBO_MULT_EN
        return 1 + ((c / 10 > 3) ? 3 : c / 10);
`else
        return 1;
`endif
    endfunction

    task automatic model_step();
        int p;
        if (reset) begin
            for (int i = 0; i < NL; i++) mpend[i] = 1'b0;
            expq.delete();
            m_score = 0; m_combo = 0; m_max = 0; m_drop = 0;
            cyc = -1;
            return;
        end
        p = cyc % NL;
        if (mpend[p]) begin
            expq.push_back('{cyc + 3, p, grade_of(song_time, mt[p])});
            mpend[p] = 1'b0;
        end
        for (int i = 0; i < NL; i++) begin
            if (match_trigger[i]) begin
                if (mpend[i]) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
                mt[i]    = match_time[16*i +: 16];
                mpend[i] = 1'b1;
            end
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (hit_valid === 1'b1) begin
            hit_cnt++;
            hit_lanes.push_back(int'(hit_lane));
            last_lane  = int'(hit_lane);
            last_grade = int'(hit_grade);
        end
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            chk("hit_valid", hit_valid, 1);
            chk("hit_lane", hit_lane, e.lane);
            chk("hit_grade", hit_grade, e.grade);
            if (e.grade == 0) begin
                m_combo = 0;
            end else begin
                m_score += ((e.grade == 2) ? 10 : 5) * mult_of(m_combo);
                if (m_score > 24'hFFFFFF) m_score = 24'hFFFFFF;
                m_combo = (m_combo >= 65535) ? 65535 : m_combo + 1;
            end
            if (m_combo > m_max) m_max = m_combo;
        end else begin
            chk("hit_valid_idle", hit_valid, 0);
        end
        chk("score", score, m_score);
        chk("combo", combo, m_combo);
        chk("max_combo", max_combo, m_max);
        chk("drop_count", drop_count, m_drop);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (armed) check_cycle();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        match_trigger = '0;
        tick();
        armed = 1'b1;
        tick();
        reset = 1'b0;
        hit_cnt = 0;
        hit_lanes.delete();
    endtask

    task automatic set_lane(input int lane, input logic [15:0] t);
        match_trigger[lane] = 1'b1;
        match_time[16*lane +: 16] = t;
    endtask

    typedef struct {
        int          lane;
        logic [15:0] mtime;
        logic [15:0] stime;
        int          grade;
        int          pts;
        int          cmb;
    } vec_t;

    vec_t vecs [8];

    initial begin
        reset = 1'b1;
        song_time = '0;
        match_trigger = '0;
        match_time = '0;

        vecs[0] = '{5,  16'd100,   16'd101,   2, 10, 1};
        vecs[1] = '{12, 16'd200,   16'd208,   1, 5,  1};
        vecs[2] = '{20, 16'd200,   16'd209,   0, 0,  0};
        vecs[3] = '{3,  16'hFFFE,  16'h0001,  2, 10, 1};
        vecs[4] = '{36, 16'd50,    16'd46,    1, 5,  1};
        vecs[5] = '{0,  16'd50,    16'd47,    2, 10, 1};
        vecs[6] = '{10, 16'd1000,  16'd991,   0, 0,  0};
        vecs[7] = '{30, 16'h8000,  16'h0000,  0, 0,  0};

        // Single-hit grading table, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            chk("reset_score", score, 0);
            song_time = vecs[v].stime;
            set_lane(vecs[v].lane, vecs[v].mtime);
            tick();
            match_trigger = '0;
            run(45);
            chk("vec_hits", hit_cnt, 1);
            chk("vec_lane", last_lane, vecs[v].lane);
            chk("vec_grade", last_grade, vecs[v].grade);
            chk("vec_score", score, vecs[v].pts);
            chk("vec_combo", combo, vecs[v].cmb);
        end

        // Three lanes at once, scanned from pointer 21 onward.
        do_reset();
        song_time = 16'd500;
        run(20);
        set_lane(0, 16'd500);
        set_lane(12, 16'd500);
        set_lane(36, 16'd500);
        tick();
        match_trigger = '0;
        run(45);
        chk("multi_hits", hit_cnt, 3);
        if (hit_lanes.size() == 3) begin
            chk("multi_order0", hit_lanes[0], 36);
            chk("multi_order1", hit_lanes[1], 0);
            chk("multi_order2", hit_lanes[2], 12);
        end
        chk("multi_drop", drop_count, 0);
        chk("multi_score", score, 30);

        // PERFECT, GOOD (err 8), MISS (err 9): combo cleared, max kept.
        do_reset();
        song_time = 16'd100;
        set_lane(1, 16'd100);
        set_lane(2, 16'd92);
        set_lane(3, 16'd91);
        tick();
        match_trigger = '0;
        run(10);
        chk("seq_hits", hit_cnt, 3);
        chk("seq_score", score, 15);
        chk("seq_combo", combo, 0);
        chk("seq_max", max_combo, 2);

        // Overwrite before scan counts a drop; retrigger on the scan cycle does not.
        do_reset();
        song_time = 16'd200;
        set_lane(7, 16'd100); tick(); match_trigger = '0;
        set_lane(7, 16'd200); tick(); match_trigger = '0;
        set_lane(9, 16'd200); tick(); match_trigger = '0;
        run(6);
        set_lane(9, 16'd0); tick(); match_trigger = '0;
        run(45);
        chk("drop_one", drop_count, 1);
        chk("drop_hits", hit_cnt, 3);
        if (hit_lanes.size() == 3) begin
            chk("drop_lane0", hit_lanes[0], 7);
            chk("drop_lane2", hit_lanes[2], 9);
        end
        chk("drop_score", score, 20);
        chk("drop_max", max_combo, 2);

        // 40 consecutive PERFECTs.
        do_reset();
        song_time = 16'd1000;
        for (int i = 0; i < NL; i++) set_lane(i, 16'd1000);
        tick();
        match_trigger = '0;
        run(40);
        for (int i = 0; i < 3; i++) set_lane(i, 16'd1000);
        tick();
        match_trigger = '0;
        run(45);
        chk("p40_hits", hit_cnt, 40);
`ifdef SC_COMBO_MULT_EN
        chk("p40_score", score, 1000);
`else
        chk("p40_score", score, 400);
`endif
        chk("p40_combo", combo, 40);
        chk("p40_max", max_combo, 40);

        // Drop counter saturates at 255.
        do_reset();
        song_time = 16'd10;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NL; i++) set_lane(i, 16'd10);
            tick();
        end
        match_trigger = '0;
        chk("drop_sat", drop_count, 255);
        run(42);

        // Reset with hits pending and one in flight: nothing emerges afterwards.
        do_reset();
        song_time = 16'd0;
        set_lane(1, 16'd0);
        set_lane(30, 16'd0);
        set_lane(31, 16'd0);
        set_lane(32, 16'd0);
        tick();
        match_trigger = '0;
        set_lane(31, 16'd0);
        tick();
        match_trigger = '0;
        do_reset();
        run(60);
        chk("rst_hits", hit_cnt, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_max", max_combo, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_valid", hit_valid, 0);

        // Randomized traffic against the model.
        do_reset();
        song_time = 16'($urandom);
        for (int c = 0; c < 800; c++) begin
            song_time = song_time + 16'd1;
            match_trigger = '0;
            for (int i = 0; i < NL; i++) begin
                if ((c % 200 == 199) || ($urandom_range(0, 39) == 0))
                    set_lane(i, song_time + 16'd12 - 16'($urandom_range(0, 24)));
            end
            tick();
        end
        match_trigger = '0;
        run(45);
        chk("rand_drain", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
